aes_round_unit: RTL and testbench



---
 rtl/aes_round_unit_if.sv | 22 ++
 rtl/aes_round_unit.sv | 117 +++++++++++
 tb/tb_aes_round_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_unit_if.sv
// Bus bundle for aes_round_unit: round-state input/output, round key and the
// standalone S-box word path. The master drives inputs; the slave is the round unit.
interface aes_round_unit_if;
    logic         in_valid;
    logic [127:0] state_in;
    logic         final_in;
    logic [127:0] key_in;
    logic [127:0] state_out;
    logic         out_valid;
    logic [31:0]  word_in;
    logic [31:0]  word_out;

    modport master (
        output in_valid, state_in, final_in, key_in, word_in,
        input  state_out, out_valid, word_out
    );

    modport slave (
        input  in_valid, state_in, final_in, key_in, word_in,
        output state_out, out_valid, word_out
    );
endinterface

// File: rtl/aes_round_unit.sv
// Two-stage pipelined AES encryption round (middle or final) plus a registered
// 4-byte S-box word path. Define AES_ROUND_KEY_ALIGN_EN to sample key_in with state_in.
module aes_round_unit (
    input  logic           clk,
    input  logic           rst_n,
    aes_round_unit_if.slave bus
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as a^254 (0 maps to 0), followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [127:0] s1_state_d, s1_state_q;
    logic         s1_final_q;
    logic         s1_valid_q;
    logic [127:0] mixed;
    logic [127:0] round_key;
    logic [127:0] state_out_d, state_out_q;
    logic         out_valid_q;
    logic [31:0]  word_d, word_q;

    // SubBytes and ShiftRows: output byte (row r, col c) takes input column (c + r) mod 4.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ((COL + ROW) % 4) * 4 + ROW;
            assign s1_state_d[127-8*gi -: 8] = sbox(bus.state_in[127-8*SRC -: 8]);
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = s1_state_q[127-32*gi -: 8];
            assign a1 = s1_state_q[119-32*gi -: 8];
            assign a2 = s1_state_q[111-32*gi -: 8];
            assign a3 = s1_state_q[103-32*gi -: 8];
            assign mixed[127-32*gi -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            assign word_d[31-8*gi -: 8] = sbox(bus.word_in[31-8*gi -: 8]);
        end
    endgenerate

`ifdef AES_ROUND_KEY_ALIGN_EN
    logic [127:0] key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
        end else begin
            key_q <= bus.key_in;
        end
    end

    assign round_key = key_q;
`else
    // Key arrives one cycle behind its state, straight into stage 2.
    assign round_key = bus.key_in;
`endif

    assign state_out_d = (s1_final_q ? s1_state_q : mixed) ^ round_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_state_q  <= '0;
            s1_final_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            state_out_q <= '0;
            out_valid_q <= 1'b0;
            word_q      <= '0;
        end else begin
            s1_state_q  <= s1_state_d;
            s1_final_q  <= bus.final_in;
            s1_valid_q  <= bus.in_valid;
            state_out_q <= state_out_d;
            out_valid_q <= s1_valid_q;
            word_q      <= word_d;
        end
    end

    assign bus.state_out = state_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.word_out  = word_q;

endmodule

// File: tb/tb_aes_round_unit.sv
// Scoreboard bench for aes_round_unit: directed FIPS-197 round vectors and S-box words,
// expected results queued at issue time and checked by an independent monitor.
module tb_aes_round_unit;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;

    aes_round_unit_if bus ();

    aes_round_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [127:0] exp;
    } rexp_t;

    typedef struct {
        int          due;
        logic [31:0] exp;
    } wexp_t;

    rexp_t rq[$];
    wexp_t wq[$];

    // Directed vectors: 0 = FIPS-197 C.1 round 1 (middle), 1 = round 10 (final).
    logic [127:0] v_state [2];
    logic [127:0] v_key   [2];
    logic [127:0] v_exp   [2];
    logic         v_final [2];

    bit prev_v;
    int prev_idx;

    task automatic step(input bit v, input int idx,
                        input bit wv, input logic [31:0] w, input logic [31:0] wexp);
        rexp_t e;
        wexp_t we;
        bus.in_valid = v;
        bus.state_in = v ? v_state[idx] : {$urandom, $urandom, $urandom, $urandom};
        bus.final_in = v ? v_final[idx] : 1'($urandom);
`ifdef AES_ROUND_KEY_ALIGN_EN
        bus.key_in   = v ? v_key[idx] : {$urandom, $urandom, $urandom, $urandom};
`else
        bus.key_in   = prev_v ? v_key[prev_idx] : {$urandom, $urandom, $urandom, $urandom};
`endif
        bus.word_in  = wv ? w : $urandom;
        if (v) begin
            e.due = cyc + 2;
            e.exp = v_exp[idx];
            rq.push_back(e);
        end
        if (wv) begin
            we.due = cyc + 1;
            we.exp = wexp;
            wq.push_back(we);
        end
        prev_v   = v;
        prev_idx = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: checks reset-zero outputs, the out_valid pattern and each due result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                checks++;
                if (bus.state_out !== 128'h0 || bus.out_valid !== 1'b0 || bus.word_out !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_zero: state_out=%h out_valid=%b word_out=%h required all 0",
                             bus.state_out, bus.out_valid, bus.word_out);
                end
            end else begin
                while (rq.size() > 0 && rq[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL round_missed: due cycle %0d passed, now %0d", rq[0].due, cyc);
                    void'(rq.pop_front());
                end
                checks++;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    if (bus.out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL out_valid: got %b required 1 at cycle %0d", bus.out_valid, cyc);
                    end
                    checks++;
                    if (bus.state_out !== rq[0].exp) begin
                        errors++;
                        $display("FAIL round_data: got %h required %h", bus.state_out, rq[0].exp);
                    end else begin
                        $display("round result cycle %0d: %h ok", cyc, bus.state_out);
                    end
                    void'(rq.pop_front());
                end else if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL out_valid: got %b required 0 at cycle %0d", bus.out_valid, cyc);
                end
                if (wq.size() > 0 && wq[0].due == cyc) begin
                    checks++;
                    if (bus.word_out !== wq[0].exp) begin
                        errors++;
                        $display("FAIL word_sbox: got %h required %h", bus.word_out, wq[0].exp);
                    end else begin
                        $display("word result cycle %0d: %h ok", cyc, bus.word_out);
                    end
                    void'(wq.pop_front());
                end
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        prev_v   = 1'b0;
        prev_idx = 0;
        mon_en   = 1'b0;

        v_state[0] = 128'h00102030405060708090a0b0c0d0e0f0;
        v_key[0]   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        v_exp[0]   = 128'h89d810e8855ace682d1843d8cb128fe4;
        v_final[0] = 1'b0;
        v_state[1] = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
        v_key[1]   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        v_exp[1]   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        v_final[1] = 1'b1;

        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.state_in = '0;
        bus.final_in = 1'b0;
        bus.key_in   = '0;
        bus.word_in  = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with random inputs, valid asserted.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.state_in = {$urandom, $urandom, $urandom, $urandom};
            bus.key_in   = {$urandom, $urandom, $urandom, $urandom};
            bus.word_in  = $urandom;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle(3);

        // S-box word path.
        step(1'b0, 0, 1'b1, 32'h00000000, 32'h63636363);
        step(1'b0, 0, 1'b1, 32'h0153ff00, 32'h7ced1663);
        step(1'b0, 0, 1'b1, 32'h53ff0100, 32'hed167c63);
        idle(2);

        // Single middle round, then single final round.
        step(1'b1, 0, 1'b0, 32'h0, 32'h0);
        idle(3);
        step(1'b1, 1, 1'b0, 32'h0, 32'h0);
        idle(3);

        // Streaming: round 1, round 10, bubble, round 1 -> valid pattern 1,1,0,1.
        step(1'b1, 0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1, 1'b0, 32'h0, 32'h0);
        step(1'b0, 0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 0, 1'b0, 32'h0, 32'h0);
        idle(3);

        // Mid-flight reset: the in-flight round is discarded.
        step(1'b1, 1, 1'b0, 32'h0, 32'h0);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        rq.delete();
        prev_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1, 1'b0, 32'h0, 32'h0);
        idle(5);

        checks++;
        if (rq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d round and %0d word results outstanding, required 0",
                     rq.size(), wq.size());
        end
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
